// File: rtl/gf_pe_pkg.sv
// Shared definitions for the vectorised GF(2^m) processing element:
// operation codes and the default reduction polynomials.
package gf_pe_pkg;

    localparam int MODE_W = 3;

    typedef enum logic [MODE_W-1:0] {
        PASS  = 3'b000,
        LOAD  = 3'b001,
        MAC   = 3'b010,
        SCALE = 3'b011,
        ELIM  = 3'b100,
        DRAIN = 3'b101
    } gf_mode_e;

    localparam logic [8:0] POLY_GF16  = 9'h013;
    localparam logic [8:0] POLY_GF256 = 9'h11B;

endpackage

// File: rtl/gf_pe_vec_mul_lane.sv
// Combinational GF(2^m) multiplier: shift-and-add with the reduction
// folded into every shift of the multiplicand.
module gf_mul_lane #(
    parameter int              GF_BIT = 4,
    parameter logic [GF_BIT:0] POLY   = 'h13
) (
    input  logic [GF_BIT-1:0] a_in,
    input  logic [GF_BIT-1:0] b_in,
    output logic [GF_BIT-1:0] p_out
);

    localparam logic [GF_BIT-1:0] RED = POLY[GF_BIT-1:0];

    logic [GF_BIT-1:0] sh;

    always_comb begin
        p_out = '0;
        sh    = a_in;
        for (int k = 0; k < GF_BIT; k++) begin
            if (b_in[k]) begin
                p_out = p_out ^ sh;
            end
            // multiply the running term by x, dropping x^m back in via POLY
            sh = {sh[GF_BIT-2:0], 1'b0} ^ (sh[GF_BIT-1] ? RED : '0);
        end
    end

endmodule

// File: rtl/gf_pe_vec.sv
// LANES-wide GF(2^m) processing element with private per-lane accumulators,
// broadcast coefficient and fully registered forwarding of valid/mode/coef.
module gf_pe_vec
    import gf_pe_pkg::*;
#(
    parameter int              GF_BIT = 4,
    parameter int              LANES  = 4,
    parameter logic [GF_BIT:0] POLY   = 'h13,
    parameter int              IN_REG = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [MODE_W-1:0]       mode_in,
    input  logic [GF_BIT-1:0]       coef_in,
    input  logic [LANES*GF_BIT-1:0] data_in,
    output logic                    out_valid,
    output logic [MODE_W-1:0]       mode_out,
    output logic [GF_BIT-1:0]       coef_out,
    output logic [LANES*GF_BIT-1:0] data_out,
    output logic [LANES*GF_BIT-1:0] acc_out,
    output logic                    err
);

    localparam int W = LANES * GF_BIT;

    logic              ex_valid;
    logic [MODE_W-1:0] ex_mode;
    logic [GF_BIT-1:0] ex_coef;
    logic [W-1:0]      ex_data;

    generate
        if (IN_REG != 0) begin : g_in_reg
            logic              s1_valid_q, s1_valid_d;
            logic [MODE_W-1:0] s1_mode_q, s1_mode_d;
            logic [GF_BIT-1:0] s1_coef_q, s1_coef_d;
            logic [W-1:0]      s1_data_q, s1_data_d;

            always_comb begin
                s1_valid_d = in_valid;
                s1_mode_d  = mode_in;
                s1_coef_d  = coef_in;
                s1_data_d  = data_in;
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s1_valid_q <= 1'b0;
                    s1_mode_q  <= PASS;
                    s1_coef_q  <= '0;
                    s1_data_q  <= '0;
                end else begin
                    s1_valid_q <= s1_valid_d;
                    s1_mode_q  <= s1_mode_d;
                    s1_coef_q  <= s1_coef_d;
                    s1_data_q  <= s1_data_d;
                end
            end

            assign ex_valid = s1_valid_q;
            assign ex_mode  = s1_mode_q;
            assign ex_coef  = s1_coef_q;
            assign ex_data  = s1_data_q;
        end else begin : g_no_in_reg
            assign ex_valid = in_valid;
            assign ex_mode  = mode_in;
            assign ex_coef  = coef_in;
            assign ex_data  = data_in;
        end
    endgenerate

    logic [W-1:0]      acc_q, acc_d;
    logic [W-1:0]      data_out_q, data_out_d;
    logic              out_valid_q, out_valid_d;
    logic [MODE_W-1:0] mode_out_q, mode_out_d;
    logic [GF_BIT-1:0] coef_out_q, coef_out_d;
    logic              err_q, err_d;
    logic [W-1:0]      p_vec;
    logic [W-1:0]      q_vec;

    // p = coef*d feeds MAC/SCALE, q = coef*acc feeds ELIM
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        gf_mul_lane #(.GF_BIT(GF_BIT), .POLY(POLY)) u_mul_p (
            .a_in  (ex_coef),
            .b_in  (ex_data[i*GF_BIT +: GF_BIT]),
            .p_out (p_vec[i*GF_BIT +: GF_BIT])
        );
        gf_mul_lane #(.GF_BIT(GF_BIT), .POLY(POLY)) u_mul_q (
            .a_in  (ex_coef),
            .b_in  (acc_q[i*GF_BIT +: GF_BIT]),
            .p_out (q_vec[i*GF_BIT +: GF_BIT])
        );
    end

    always_comb begin
        acc_d       = acc_q;
        data_out_d  = data_out_q;
        err_d       = err_q;
        out_valid_d = ex_valid;
        mode_out_d  = ex_mode;
        coef_out_d  = ex_coef;
        if (ex_valid) begin
            for (int i = 0; i < LANES; i++) begin
                case (gf_mode_e'(ex_mode))
                    PASS: begin
                        data_out_d[i*GF_BIT +: GF_BIT] = ex_data[i*GF_BIT +: GF_BIT];
                    end
                    LOAD: begin
                        acc_d[i*GF_BIT +: GF_BIT]      = ex_data[i*GF_BIT +: GF_BIT];
                        data_out_d[i*GF_BIT +: GF_BIT] = '0;
                    end
                    MAC: begin
                        acc_d[i*GF_BIT +: GF_BIT]      = acc_q[i*GF_BIT +: GF_BIT] ^ p_vec[i*GF_BIT +: GF_BIT];
                        data_out_d[i*GF_BIT +: GF_BIT] = ex_data[i*GF_BIT +: GF_BIT];
                    end
                    SCALE: begin
                        acc_d[i*GF_BIT +: GF_BIT]      = p_vec[i*GF_BIT +: GF_BIT];
                        data_out_d[i*GF_BIT +: GF_BIT] = p_vec[i*GF_BIT +: GF_BIT];
                    end
                    ELIM: begin
                        data_out_d[i*GF_BIT +: GF_BIT] = ex_data[i*GF_BIT +: GF_BIT] ^ q_vec[i*GF_BIT +: GF_BIT];
                    end
                    DRAIN: begin
                        data_out_d[i*GF_BIT +: GF_BIT] = acc_q[i*GF_BIT +: GF_BIT];
                        acc_d[i*GF_BIT +: GF_BIT]      = '0;
                    end
                    default: begin
                        data_out_d[i*GF_BIT +: GF_BIT] = ex_data[i*GF_BIT +: GF_BIT];
                        err_d                          = 1'b1;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q       <= '0;
            data_out_q  <= '0;
            out_valid_q <= 1'b0;
            mode_out_q  <= PASS;
            coef_out_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            data_out_q  <= data_out_d;
            out_valid_q <= out_valid_d;
            mode_out_q  <= mode_out_d;
            coef_out_q  <= coef_out_d;
            err_q       <= err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign mode_out  = mode_out_q;
    assign coef_out  = coef_out_q;
    assign data_out  = data_out_q;
    assign acc_out   = acc_q;
    assign err       = err_q;

endmodule

// File: tb/tb_gf_pe_vec.sv
// Directed bench for gf_pe_vec (GF16, 4 lanes) with an IN_REG=0 and an
// IN_REG=1 instance; expected outputs come from a reference model via queues.
module tb_gf_pe_vec;
    import gf_pe_pkg::*;

    typedef struct {
        logic        valid;
        logic [2:0]  mode;
        logic [3:0]  coef;
        logic [15:0] dout;
        logic [15:0] acc;
        logic        err;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid0 = 1'b0, in_valid1 = 1'b0;
    logic [2:0]  mode_in0 = '0, mode_in1 = '0;
    logic [3:0]  coef_in0 = '0, coef_in1 = '0;
    logic [15:0] data_in0 = '0, data_in1 = '0;
    logic        out_valid0, out_valid1, err0, err1;
    logic [2:0]  mode_out0, mode_out1;
    logic [3:0]  coef_out0, coef_out1;
    logic [15:0] data_out0, data_out1, acc_out0, acc_out1;

    int   n_cmp = 0;
    int   n_mis = 0;
    int   cycle = 0;
    exp_t q0[$];
    exp_t q1[$];
    logic [15:0] m_acc[2];
    logic [15:0] m_dout[2];
    logic        m_err[2];

    gf_pe_vec #(.GF_BIT(4), .LANES(4), .POLY('h13), .IN_REG(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid0), .mode_in(mode_in0),
        .coef_in(coef_in0), .data_in(data_in0), .out_valid(out_valid0),
        .mode_out(mode_out0), .coef_out(coef_out0), .data_out(data_out0),
        .acc_out(acc_out0), .err(err0)
    );

    gf_pe_vec #(.GF_BIT(4), .LANES(4), .POLY('h13), .IN_REG(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .mode_in(mode_in1),
        .coef_in(coef_in1), .data_in(data_in1), .out_valid(out_valid1),
        .mode_out(mode_out1), .coef_out(coef_out1), .data_out(data_out1),
        .acc_out(acc_out1), .err(err1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // full carry-less product, then long division by x^4+x+1
    function automatic logic [3:0] gf_mul_ref(input logic [3:0] a, input logic [3:0] b);
        logic [7:0] prod;
        prod = '0;
        for (int i = 0; i < 4; i++)
            if (b[i]) prod = prod ^ ({4'b0, a} << i);
        for (int k = 7; k >= 4; k--)
            if (prod[k]) prod = prod ^ (8'h13 << (k - 4));
        return prod[3:0];
    endfunction

    task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_mis++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check_entry(input int inst, input exp_t e);
        string p;
        p = $sformatf("u%0d_due%0d", inst, e.due);
        if (inst == 0) begin
            check_output({p, "_valid"}, {15'b0, out_valid0}, {15'b0, e.valid});
            check_output({p, "_mode"},  {13'b0, mode_out0},  {13'b0, e.mode});
            check_output({p, "_coef"},  {12'b0, coef_out0},  {12'b0, e.coef});
            check_output({p, "_data"},  data_out0, e.dout);
            check_output({p, "_acc"},   acc_out0,  e.acc);
            check_output({p, "_err"},   {15'b0, err0},       {15'b0, e.err});
        end else begin
            check_output({p, "_valid"}, {15'b0, out_valid1}, {15'b0, e.valid});
            check_output({p, "_mode"},  {13'b0, mode_out1},  {13'b0, e.mode});
            check_output({p, "_coef"},  {12'b0, coef_out1},  {12'b0, e.coef});
            check_output({p, "_data"},  data_out1, e.dout);
            check_output({p, "_acc"},   acc_out1,  e.acc);
            check_output({p, "_err"},   {15'b0, err1},       {15'b0, e.err});
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                while (q0.size() > 0 && q0[0].due <= cycle) check_entry(0, q0.pop_front());
                while (q1.size() > 0 && q1[0].due <= cycle) check_entry(1, q1.pop_front());
            end
        end
    end

    // called at a negedge; returns at the next negedge
    task automatic apply_stimulus(input int inst, input logic v, input logic [2:0] m,
                                  input logic [3:0] c, input logic [15:0] d);
        exp_t        e;
        logic [15:0] acc, dout;
        logic        er;
        logic [3:0]  di, ai, p, q;
        acc  = m_acc[inst];
        dout = m_dout[inst];
        er   = m_err[inst];
        if (v) begin
            for (int l = 0; l < 4; l++) begin
                di = d[l*4 +: 4];
                ai = m_acc[inst][l*4 +: 4];
                p  = gf_mul_ref(c, di);
                q  = gf_mul_ref(c, ai);
                case (m)
                    3'b000: dout[l*4 +: 4] = di;
                    3'b001: begin acc[l*4 +: 4] = di; dout[l*4 +: 4] = 4'h0; end
                    3'b010: begin acc[l*4 +: 4] = ai ^ p; dout[l*4 +: 4] = di; end
                    3'b011: begin acc[l*4 +: 4] = p; dout[l*4 +: 4] = p; end
                    3'b100: dout[l*4 +: 4] = di ^ q;
                    3'b101: begin dout[l*4 +: 4] = ai; acc[l*4 +: 4] = 4'h0; end
                    default: begin dout[l*4 +: 4] = di; er = 1'b1; end
                endcase
            end
        end
        m_acc[inst]  = acc;
        m_dout[inst] = dout;
        m_err[inst]  = er;
        e.valid = v; e.mode = m; e.coef = c; e.dout = dout; e.acc = acc; e.err = er;
        e.due   = cycle + ((inst == 0) ? 1 : 2);
        if (inst == 0) begin
            q0.push_back(e);
            in_valid0 = v; mode_in0 = m; coef_in0 = c; data_in0 = d;
            in_valid1 = 1'b0;
        end else begin
            q1.push_back(e);
            in_valid1 = v; mode_in1 = m; coef_in1 = c; data_in1 = d;
            in_valid0 = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic clear_model();
        q0.delete();
        q1.delete();
        for (int i = 0; i < 2; i++) begin
            m_acc[i] = '0; m_dout[i] = '0; m_err[i] = 1'b0;
        end
    endtask

    task automatic drain_queues();
        for (int i = 0; i < 10 && (q0.size() > 0 || q1.size() > 0); i++) @(negedge clk);
        check_output("drain_timeout", 16'(q0.size() + q1.size()), 16'h0);
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_u0_valid"}, {15'b0, out_valid0}, 16'h0);
        check_output({tag, "_u0_mode"},  {13'b0, mode_out0},  16'h0);
        check_output({tag, "_u0_coef"},  {12'b0, coef_out0},  16'h0);
        check_output({tag, "_u0_data"},  data_out0, 16'h0);
        check_output({tag, "_u0_acc"},   acc_out0,  16'h0);
        check_output({tag, "_u0_err"},   {15'b0, err0},       16'h0);
        check_output({tag, "_u1_valid"}, {15'b0, out_valid1}, 16'h0);
        check_output({tag, "_u1_mode"},  {13'b0, mode_out1},  16'h0);
        check_output({tag, "_u1_coef"},  {12'b0, coef_out1},  16'h0);
        check_output({tag, "_u1_data"},  data_out1, 16'h0);
        check_output({tag, "_u1_acc"},   acc_out1,  16'h0);
        check_output({tag, "_u1_err"},   {15'b0, err1},       16'h0);
    endtask

    task automatic do_reset();
        drain_queues();
        rst = 1'b1;
        in_valid0 = 1'b0; in_valid1 = 1'b0;
        clear_model();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        clear_model();
        @(negedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        $display("[TB] LOAD then MAC on IN_REG=0");
        apply_stimulus(0, 1'b1, LOAD, 4'h0, 16'h4321);
        check_output("load_acc", acc_out0, 16'h4321);
        check_output("load_data", data_out0, 16'h0000);
        apply_stimulus(0, 1'b1, MAC, 4'h2, 16'h9999);
        check_output("mac_acc", acc_out0, 16'h5230);
        check_output("mac_data", data_out0, 16'h9999);
        do_reset();

        $display("[TB] SCALE then ELIM");
        apply_stimulus(0, 1'b1, SCALE, 4'h3, 16'h7777);
        check_output("scale_acc", acc_out0, 16'h9999);
        check_output("scale_data", data_out0, 16'h9999);
        apply_stimulus(0, 1'b1, ELIM, 4'h2, 16'h0000);
        check_output("elim_data", data_out0, 16'h1111);

        $display("[TB] DRAIN, idle hold, DRAIN then MAC");
        apply_stimulus(0, 1'b1, LOAD, 4'h0, 16'hABCD);
        apply_stimulus(0, 1'b1, DRAIN, 4'h0, 16'h0000);
        check_output("drain_data", data_out0, 16'hABCD);
        check_output("drain_acc", acc_out0, 16'h0000);
        apply_stimulus(0, 1'b0, PASS, 4'h0, 16'h5555);
        check_output("idle_hold_data", data_out0, 16'hABCD);
        check_output("idle_valid", {15'b0, out_valid0}, 16'h0);
        apply_stimulus(0, 1'b1, MAC, 4'h5, 16'h1234);

        $display("[TB] coef=0 corner cases");
        apply_stimulus(0, 1'b1, LOAD, 4'h0, 16'h8C3E);
        apply_stimulus(0, 1'b1, MAC, 4'h0, 16'hFFFF);
        check_output("mac_c0_acc", acc_out0, 16'h8C3E);
        apply_stimulus(0, 1'b1, ELIM, 4'h0, 16'h1357);
        check_output("elim_c0_data", data_out0, 16'h1357);
        apply_stimulus(0, 1'b1, SCALE, 4'h0, 16'hFFFF);
        check_output("scale_c0_acc", acc_out0, 16'h0000);

        $display("[TB] reserved modes and sticky err");
        apply_stimulus(0, 1'b0, 3'b111, 4'h1, 16'h0000);
        check_output("idle_rsv_err", {15'b0, err0}, 16'h0);
        apply_stimulus(0, 1'b1, 3'b110, 4'h4, 16'h2468);
        check_output("rsv_err", {15'b0, err0}, 16'h1);
        check_output("rsv_pass", data_out0, 16'h2468);
        apply_stimulus(0, 1'b1, LOAD, 4'h1, 16'h1111);
        check_output("err_sticky", {15'b0, err0}, 16'h1);
        drain_queues();

        $display("[TB] IN_REG=1 latency and back-to-back");
        apply_stimulus(1, 1'b0, PASS, 4'h0, 16'h0000);
        apply_stimulus(1, 1'b0, PASS, 4'h0, 16'h0000);
        apply_stimulus(1, 1'b1, LOAD, 4'h7, 16'h1111);
        check_output("lat_cyc1_valid", {15'b0, out_valid1}, 16'h0);
        apply_stimulus(1, 1'b0, PASS, 4'h0, 16'h0000);
        check_output("lat_cyc2_valid", {15'b0, out_valid1}, 16'h1);
        check_output("lat_cyc2_coef", {12'b0, coef_out1}, 16'h7);
        check_output("lat_cyc2_acc", acc_out1, 16'h1111);
        apply_stimulus(1, 1'b1, LOAD, 4'h0, 16'h0102);
        apply_stimulus(1, 1'b1, MAC, 4'h3, 16'h4444);
        apply_stimulus(1, 1'b1, ELIM, 4'h2, 16'h5555);
        apply_stimulus(1, 1'b0, PASS, 4'h0, 16'h0000);
        check_output("b2b_elim_data", data_out1, 16'hECEA);
        check_output("b2b_mac_acc", acc_out1, 16'hCDCE);
        drain_queues();

        $display("[TB] async reset with beat in stage 1");
        in_valid0 = 1'b0;
        in_valid1 = 1'b1; mode_in1 = LOAD; coef_in1 = 4'h5; data_in1 = 16'hFFFF;
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_all_zero("async_rst");
        @(negedge clk);
        in_valid1 = 1'b0;
        clear_model();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_output("post_rst_valid1", {15'b0, out_valid1}, 16'h0);
        check_output("post_rst_acc1", acc_out1, 16'h0000);
        @(negedge clk);
        check_output("post_rst_valid2", {15'b0, out_valid1}, 16'h0);
        check_output("post_rst_acc2", acc_out1, 16'h0000);
        check_output("post_rst_data2", data_out1, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout observed=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
